// File: rtl/module_control_unit_if.sv
// rtl/module_control_unit_if.sv - instruction, ALU and display signals of the control unit
interface module_control_unit_if #(
  parameter int DATA_W = 16
);
  logic              instr_valid;
  logic              instr_ready;
  logic [16:0]       instr;
  logic [2:0]        alu_opcode;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [DATA_W-1:0] alu_result;
  logic [DATA_W-1:0] disp_value;
  logic              disp_valid;
  logic              done;
  logic              busy;

  // Control unit side
  modport slave (
    input  instr_valid, instr, alu_result,
    output instr_ready, alu_opcode, alu_a, alu_b, disp_value, disp_valid, done, busy
  );

  // Instruction source / ALU / display side
  modport master (
    output instr_valid, instr, alu_result,
    input  instr_ready, alu_opcode, alu_a, alu_b, disp_value, disp_valid, done, busy
  );
endinterface

// File: rtl/module_control_unit.sv
// rtl/module_control_unit.sv - four-state sequencer owning the register file and driving the ALU
module module_control_unit #(
  parameter int NUM_REGS = 16,
  parameter int DATA_W   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  module_control_unit_if.slave  bus
);

  localparam int AW = $clog2(NUM_REGS);

  localparam logic [2:0] OP_LOAD  = 3'b000;
  localparam logic [2:0] OP_ADD   = 3'b001;
  localparam logic [2:0] OP_ADDI  = 3'b010;
  localparam logic [2:0] OP_SUB   = 3'b011;
  localparam logic [2:0] OP_SUBI  = 3'b100;
  localparam logic [2:0] OP_MUL   = 3'b101;
  localparam logic [2:0] OP_CLEAR = 3'b110;
  localparam logic [2:0] OP_DSPLY = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DECODE,
    S_EXECUTE,
    S_WRITEBACK
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [16:0]       r_instr;
  logic [DATA_W-1:0] r_regs [NUM_REGS];
  logic [DATA_W-1:0] r_result;
  logic [2:0]        r_alu_opcode;
  logic [DATA_W-1:0] r_alu_a;
  logic [DATA_W-1:0] r_alu_b;
  logic [DATA_W-1:0] r_disp_value;

  logic              w_ready;
  logic              w_busy;
  logic              w_done;
  logic              w_disp_valid;
  logic [DATA_W-1:0] w_a;
  logic [DATA_W-1:0] w_b;

  // Fields of the latched instruction word
  logic [2:0]        w_op;
  logic [AW-1:0]     w_rd;
  logic [AW-1:0]     w_rs1;
  logic [AW-1:0]     w_rs2;
  logic [DATA_W-1:0] w_imm6_sx;
  logic [DATA_W-1:0] w_imm10_sx;

  assign w_op       = r_instr[16:14];
  assign w_rd       = r_instr[13:10];
  assign w_rs1      = r_instr[9:6];
  assign w_rs2      = r_instr[5:2];
  assign w_imm6_sx  = {{(DATA_W-6){r_instr[5]}}, r_instr[5:0]};
  assign w_imm10_sx = {{(DATA_W-10){r_instr[9]}}, r_instr[9:0]};

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state and handshake/status outputs
  always_comb begin
    w_next       = r_state;
    w_ready      = 1'b0;
    w_busy       = 1'b1;
    w_done       = 1'b0;
    w_disp_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_ready = 1'b1;
        w_busy  = 1'b0;
        if (bus.instr_valid) w_next = S_DECODE;
      end
      S_DECODE:  w_next = S_EXECUTE;
      S_EXECUTE: w_next = S_WRITEBACK;
      S_WRITEBACK: begin
        w_done       = 1'b1;
        w_disp_valid = (w_op == OP_DSPLY);
        w_next       = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Latch the instruction word on the accept edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                       r_instr <= '0;
    else if (r_state == S_IDLE && bus.instr_valid) r_instr <= bus.instr;
  end

  // Operand selection from the register file and immediates
  always_comb begin
    w_a = '0;
    w_b = '0;
    case (w_op)
      OP_LOAD:                w_b = w_imm10_sx;
      OP_ADD, OP_SUB, OP_MUL: begin
        w_a = r_regs[w_rs1];
        w_b = r_regs[w_rs2];
      end
      OP_ADDI, OP_SUBI: begin
        w_a = r_regs[w_rs1];
        w_b = w_imm6_sx;
      end
      OP_DSPLY:               w_a = r_regs[w_rs1];
      default: begin
        w_a = '0;
        w_b = '0;
      end
    endcase
  end

  // ALU port registers, loaded at the end of DECODE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_alu_opcode <= '0;
      r_alu_a      <= '0;
      r_alu_b      <= '0;
    end else if (r_state == S_DECODE) begin
      r_alu_opcode <= w_op;
      r_alu_a      <= w_a;
      r_alu_b      <= w_b;
    end
  end

  // Result capture at the end of EXECUTE; the display register takes the same value so it is
  // already current during the WRITEBACK cycle in which disp_valid pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_result     <= '0;
      r_disp_value <= '0;
    end else if (r_state == S_EXECUTE) begin
      r_result <= bus.alu_result;
      if (w_op == OP_DSPLY) r_disp_value <= bus.alu_result;
    end
  end

  // Register file write-back on the edge leaving WRITEBACK
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else if (r_state == S_WRITEBACK && w_op != OP_DSPLY) begin
      r_regs[w_rd] <= r_result;
    end
  end

  assign bus.instr_ready = w_ready;
  assign bus.busy        = w_busy;
  assign bus.done        = w_done;
  assign bus.disp_valid  = w_disp_valid;
  assign bus.disp_value  = r_disp_value;
  assign bus.alu_opcode  = r_alu_opcode;
  assign bus.alu_a       = r_alu_a;
  assign bus.alu_b       = r_alu_b;

endmodule

// File: doc/module_control_unit.md
# module_control_unit

Multi-cycle sequencer for the CPU datapath. Accepts one 17-bit instruction at a time over a valid/ready handshake and owns the 16×16-bit signed register file. It drives the combinational ALU's opcode and operand ports, captures its result, and writes the result back or presents it on the display output. It sits between the instruction source (switches/ROM stepper) and the ALU and display driver.

## Interface
Parameters:
- NUM_REGS, 16, register-file depth (fixed power of two; address width 4)
- DATA_W, 16, register and ALU operand width

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- instr_valid  in  1  instruction word present
- instr_ready  out  1  controller can accept (high only in IDLE)
- instr  in  17  [16:14] opcode, [13:10] rd, [9:6] rs1, [5:2] rs2, [5:0] imm6, [9:0] imm10
- alu_opcode  out  3  opcode to ALU (registered)
- alu_a  out  16  ALU operand A (registered)
- alu_b  out  16  ALU operand B (registered)
- alu_result  in  16  combinational ALU result
- disp_value  out  16  last displayed value, held until next DSPLY
- disp_valid  out  1  one-cycle pulse when disp_value updates
- done  out  1  one-cycle pulse when an instruction retires
- busy  out  1  high in any state other than IDLE

## Operation
- Opcodes: LOAD 000, ADD 001, ADDI 010, SUB 011, SUBI 100, MUL 101, CLEAR 110, DSPLY 111.
- Operand selection, done in DECODE:
  - LOAD: a=0, b=sext(imm10).
  - ADD/SUB/MUL: a=R[rs1], b=R[rs2].
  - ADDI/SUBI: a=R[rs1], b=sext(imm6).
  - CLEAR: a=0, b=0.
  - DSPLY: a=R[rs1], b=0.
- FSM:
  - IDLE→DECODE on instr_valid&&instr_ready; instr is latched on that edge.
  - DECODE→EXECUTE unconditionally.
  - EXECUTE→WRITEBACK unconditionally. alu_result is captured into a result register at the end of EXECUTE.
  - WRITEBACK→IDLE unconditionally.
- WRITEBACK:
  - Opcodes 000–110: R[rd] is written with the captured result on the exiting edge.
  - DSPLY: no register write. disp_value is loaded with the captured result and disp_valid pulses.
  - done pulses for every opcode.
- Arithmetic: two's complement. MUL keeps the low 16 bits only, with no overflow flag. ADD/SUB wrap modulo 2^16. R0 is an ordinary register, not hard-wired to zero.
- rs1==rd or rs2==rd is legal. Reads happen in DECODE, before the write.
- instr_valid while busy is ignored. The source must hold the word until instr_ready is seen.

## Timing
- Reset (async assert, sync-safe release):
  - State goes to IDLE. All 16 registers go to 0.
  - alu_opcode, alu_a, alu_b, disp_value, and the result register go to 0.
  - disp_valid, done, and busy go to 0. instr_ready goes to 1.
- Accept edge T0. DECODE runs in cycle T0+1, EXECUTE in T0+2, WRITEBACK in T0+3. done and disp_valid are high during T0+3.
- The register write is visible from T0+4. instr_ready returns high in T0+4.
- Throughput is one instruction per 4 cycles. Back-to-back instructions are accepted with no bubble beyond IDLE.
- Reset mid-instruction aborts it. No register write, done pulse, or disp_valid pulse occurs for the aborted instruction.

## Test plan
- After reset: all outputs are at their reset values. DSPLY R5 → disp_value=0 and a disp_valid pulse at T0+3.
- Latency and write: LOAD R1,#100 then DSPLY R1 → 100. LOAD R2,#-512 then DSPLY R2 → 0xFE00. Check done at exactly T0+3 and instr_ready low for cycles T0+1 to T0+3.
- Register ops: R1=100, R2=-512. SUB R3,R1,R2 → 612. ADDI R4,R1,#-32 → 68. SUBI R1,R1,#31 → 69 (same-register read-before-write).
- Wrap and truncation:
  - LOAD R1,#511; MUL R1,R1,R1 → 261121 truncated to 0xFC01.
  - Then MUL R1,R1,R1 again → 0xF801, the low 16 bits of 0xFC01², interpreted as signed.
  - ADD of 0x7FFF+1 → 0x8000.
- Handshake: instr_valid held high continuously with changing instr → only words present on IDLE edges execute. A word toggled during busy is never executed.
- Reset mid-op: assert rst during EXECUTE of LOAD R7,#5. Then DSPLY R7 → 0. No done pulse for the aborted instruction.
